// File: rtl/counter_monitor.sv
// ============================================================================
// counter_monitor
// ----------------------------------------------------------------------------
// Observer/checker for an up/down counter output stream. Samples count_in on
// valid strobes, infers the direction of each step (up, down or hold), flags
// wrap-around events and counts illegal steps (glitches).
//
// Optional feature (compile-time macro):
//   COUNTER_MON_RST_DETECT_EN - when defined, a jump to 0 that is not a legal
//   0/+1/-1 step is reported as a counter reset on rst_seen instead of a
//   glitch. When undefined, rst_seen is absent and such a jump is a glitch.
//
// Parameters:
//   WIDTH        width of the observed count
//   ERR_CNT_W    width of the saturating glitch counter
//
// Ports:
//   clk           clock, all state on rising edge
//   rst           asynchronous active-high reset
//   clr           synchronous clear (back to INIT, counters zeroed)
//   valid         count_in carries a new sample this cycle
//   count_in      observed counter value
//   state         FSM state: INIT=0, HOLD=1, UP=2, DOWN=3
//   glitch        one-cycle pulse: illegal step detected
//   wrap_up       one-cycle pulse: legal step from max to 0
//   wrap_down     one-cycle pulse: legal step from 0 to max
//   run_len       consecutive same-direction steps, saturating at 255
//   glitch_count  glitches since reset/clr, saturating
//   rst_seen      (macro only) one-cycle pulse: counter reset to 0 observed
//
// All outputs are registered; a sample taken at edge N shows after edge N.
// ============================================================================
module counter_monitor #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 valid,
    input  logic [WIDTH-1:0]     count_in,
    output logic [1:0]           state,
    output logic                 glitch,
    output logic                 wrap_up,
    output logic                 wrap_down,
    output logic [7:0]           run_len,
`ifdef COUNTER_MON_RST_DETECT_EN
    output logic [ERR_CNT_W-1:0] glitch_count,
    output logic                 rst_seen
`else
    output logic [ERR_CNT_W-1:0] glitch_count
`endif
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_HOLD = 2'd1,
        ST_UP   = 2'd2,
        ST_DOWN = 2'd3
    } mon_state_t;

    localparam logic [WIDTH-1:0]     CNT_MAX = '1;
    localparam logic [WIDTH-1:0]     STEP_UP = WIDTH'(1);
    localparam logic [7:0]           RUN_MAX = 8'hFF;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    // Registered state and outputs
    mon_state_t           cur_q;
    logic [WIDTH-1:0]     prev_q;
    logic [7:0]           run_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic                 glitch_q;
    logic                 wrap_up_q;
    logic                 wrap_down_q;
    logic                 rst_seen_q;

    // Next-state values
    mon_state_t           cur_d;
    logic [WIDTH-1:0]     prev_d;
    logic [7:0]           run_d;
    logic [ERR_CNT_W-1:0] err_d;
    logic                 glitch_d;
    logic                 wrap_up_d;
    logic                 wrap_down_d;
    logic                 rst_seen_d;

    // Modular step from the previous sample; wraps naturally at WIDTH bits.
    logic [WIDTH-1:0] delta;
    logic             zero_jump;

    assign delta = count_in - prev_q;

    // A jump to 0 that is not 0/+1/-1 is only reachable in the "other delta"
    // branch below, so count_in==0 alone identifies it there.
`ifdef COUNTER_MON_RST_DETECT_EN
    assign zero_jump = (count_in == '0);
`else
    assign zero_jump = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_q       <= ST_INIT;
            prev_q      <= '0;
            run_q       <= '0;
            err_q       <= '0;
            glitch_q    <= 1'b0;
            wrap_up_q   <= 1'b0;
            wrap_down_q <= 1'b0;
            rst_seen_q  <= 1'b0;
        end else begin
            cur_q       <= cur_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            err_q       <= err_d;
            glitch_q    <= glitch_d;
            wrap_up_q   <= wrap_up_d;
            wrap_down_q <= wrap_down_d;
            rst_seen_q  <= rst_seen_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        cur_d       = cur_q;
        prev_d      = prev_q;
        run_d       = run_q;
        err_d       = err_q;
        glitch_d    = 1'b0;
        wrap_up_d   = 1'b0;
        wrap_down_d = 1'b0;
        rst_seen_d  = 1'b0;

        if (clr) begin
            cur_d  = ST_INIT;
            prev_d = '0;
            run_d  = '0;
            err_d  = '0;
        end else if (valid) begin
            prev_d = count_in;
            if (cur_q == ST_INIT) begin
                // First sample only establishes the reference value.
                cur_d = ST_HOLD;
            end else if (delta == '0) begin
                cur_d = ST_HOLD;
                run_d = '0;
            end else if (delta == STEP_UP) begin
                cur_d     = ST_UP;
                wrap_up_d = (prev_q == CNT_MAX);
                if (cur_q != ST_UP)
                    run_d = 8'd1;
                else if (run_q != RUN_MAX)
                    run_d = run_q + 8'd1;
            end else if (delta == CNT_MAX) begin
                cur_d       = ST_DOWN;
                wrap_down_d = (prev_q == '0);
                if (cur_q != ST_DOWN)
                    run_d = 8'd1;
                else if (run_q != RUN_MAX)
                    run_d = run_q + 8'd1;
            end else if (zero_jump) begin
                cur_d      = ST_HOLD;
                run_d      = '0;
                rst_seen_d = 1'b1;
            end else begin
                // Illegal step: resynchronise on this sample via prev_d.
                cur_d    = ST_HOLD;
                run_d    = '0;
                glitch_d = 1'b1;
                if (err_q != ERR_MAX)
                    err_d = err_q + ERR_CNT_W'(1);
            end
        end
    end

    assign state        = cur_q;
    assign glitch       = glitch_q;
    assign wrap_up      = wrap_up_q;
    assign wrap_down    = wrap_down_q;
    assign run_len      = run_q;
    assign glitch_count = err_q;
`ifdef COUNTER_MON_RST_DETECT_EN
    assign rst_seen     = rst_seen_q;
`else
    // rst_seen_q is tied off in this build; keep it referenced.
    logic unused_rst_seen;
    assign unused_rst_seen = rst_seen_q;
`endif

endmodule

// File: tb/tb_counter_monitor.sv
// ============================================================================
// tb_counter_monitor
// Directed scenarios plus randomized stimulus, each cycle compared against a
// reference model computed with integer arithmetic on the step rules.
// ============================================================================
module tb_counter_monitor;

    localparam int WIDTH  = 8;
    localparam int ERR_W  = 8;
    localparam int MOD    = 1 << WIDTH;
    localparam int GC_MAX = (1 << ERR_W) - 1;
    localparam int S_INIT = 0, S_HOLD = 1, S_UP = 2, S_DOWN = 3;
`ifdef COUNTER_MON_RST_DETECT_EN
    localparam bit RST_DET = 1'b1;
`else
    localparam bit RST_DET = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             valid;
    logic [WIDTH-1:0] count_in;
    logic [1:0]       state;
    logic             glitch, wrap_up, wrap_down;
    logic [7:0]       run_len;
    logic [ERR_W-1:0] glitch_count;
    logic             rst_seen;

    counter_monitor #(.WIDTH(WIDTH), .ERR_CNT_W(ERR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .valid        (valid),
        .count_in     (count_in),
        .state        (state),
        .glitch       (glitch),
        .wrap_up      (wrap_up),
        .wrap_down    (wrap_down),
        .run_len      (run_len),
`ifdef COUNTER_MON_RST_DETECT_EN
        .glitch_count (glitch_count),
        .rst_seen     (rst_seen)
`else
        .glitch_count (glitch_count)
`endif
    );
`ifndef COUNTER_MON_RST_DETECT_EN
    assign rst_seen = 1'b0;
`endif

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_state, m_prev, m_run, m_gc;
    bit m_glitch, m_wu, m_wd, m_rs;
    int n_wrap_down, n_wrap_up, n_glitch;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = S_INIT; m_prev = 0; m_run = 0; m_gc = 0;
        m_glitch = 0; m_wu = 0; m_wd = 0; m_rs = 0;
    endtask

    task automatic model_step(input bit v, input int x, input bit c);
        int d;
        m_glitch = 0; m_wu = 0; m_wd = 0; m_rs = 0;
        if (c) begin
            model_reset();
        end else if (v) begin
            if (m_state == S_INIT) begin
                m_state = S_HOLD;
            end else begin
                d = (x - m_prev + MOD) % MOD;
                if (d == 0) begin
                    m_state = S_HOLD; m_run = 0;
                end else if (d == 1) begin
                    m_run   = (m_state == S_UP) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
                    m_state = S_UP;
                    m_wu    = (m_prev == MOD - 1);
                end else if (d == MOD - 1) begin
                    m_run   = (m_state == S_DOWN) ? ((m_run < 255) ? m_run + 1 : 255) : 1;
                    m_state = S_DOWN;
                    m_wd    = (m_prev == 0);
                end else if (RST_DET && x == 0) begin
                    m_state = S_HOLD; m_run = 0; m_rs = 1;
                end else begin
                    m_state = S_HOLD; m_run = 0; m_glitch = 1;
                    if (m_gc < GC_MAX) m_gc++;
                end
            end
            m_prev = x;
        end
    endtask

    task automatic compare_all();
        check("state",        state,        m_state);
        check("glitch",       glitch,       m_glitch);
        check("wrap_up",      wrap_up,      m_wu);
        check("wrap_down",    wrap_down,    m_wd);
        check("run_len",      run_len,      m_run);
        check("glitch_count", glitch_count, m_gc);
        check("rst_seen",     rst_seen,     m_rs);
        check("pulse_excl",   (int'(glitch) + int'(wrap_up) + int'(wrap_down) + int'(rst_seen)) <= 1, 1);
    endtask

    // Drive one cycle of inputs, clock it, then compare 1 time unit later.
    task automatic step(input bit v, input int x, input bit c);
        valid    = v;
        count_in = 8'(x);
        clr      = c;
        @(posedge clk);
        model_step(v, x, c);
        #1;
        n_wrap_down += wrap_down;
        n_wrap_up   += wrap_up;
        n_glitch    += glitch;
        compare_all();
    endtask

    task automatic sample(input int x);
        step(1'b1, x, 1'b0);
    endtask

    task automatic do_clr();
        step(1'b0, 0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r, x;
        rst = 1'b1; clr = 1'b0; valid = 1'b0; count_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        #2 rst = 1'b0;

        // Counting up
        sample(5); sample(6);
        check("up_after_2nd", state, S_UP);
        sample(7); sample(8);
        check("run_up3", run_len, 3);
        check("no_glitch_up", glitch_count, 0);

        // Counting down through wrap at 0
        do_clr();
        n_wrap_down = 0;
        sample(2); sample(1); sample(0); sample(255); sample(254);
        check("down_state", state, S_DOWN);
        check("wrap_down_once", n_wrap_down, 1);
        check("run_down4", run_len, 4);

        // Counting up through wrap at max, then hold
        do_clr();
        n_wrap_up = 0;
        sample(254); sample(255); sample(0); sample(1);
        check("wrap_up_once", n_wrap_up, 1);
        check("run_up_wrap3", run_len, 3);
        sample(1);
        check("hold_state", state, S_HOLD);
        check("hold_run0", run_len, 0);

        // Glitch and clear
        do_clr();
        sample(10); sample(11); sample(40);
        check("glitch_pulse", glitch, 1);
        check("glitch_cnt1", glitch_count, 1);
        sample(41);
        check("resync_run1", run_len, 1);
        do_clr();
        check("clr_init", state, S_INIT);
        check("clr_gcnt", glitch_count, 0);

        // valid low holds state and drops pulses
        sample(100); sample(101); sample(120);
        step(1'b0, 7, 1'b0);
        step(1'b0, 200, 1'b0);
        sample(121);

        // Async reset between edges mid-stream
        do_clr();
        for (int i = 0; i < 8; i++) sample(60 + i);
        check("pre_rst_run7", run_len, 7);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("arst_state", state, S_INIT);
        check("arst_run", run_len, 0);
        check("arst_pulses", int'(glitch) + int'(wrap_up) + int'(wrap_down) + int'(rst_seen), 0);
        check("arst_gcnt", glitch_count, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        sample(33);
        check("post_rst_noglitch", glitch, 0);
        sample(34);

        // Jump to zero mid-stream
        do_clr();
        sample(50); sample(51); sample(0);
        check("zero_jump_state", state, S_HOLD);
        check("zero_jump_glitch", glitch, RST_DET ? 0 : 1);
        check("zero_jump_gcnt", glitch_count, RST_DET ? 0 : 1);
        check("zero_jump_seen", rst_seen, RST_DET ? 1 : 0);

        // run_len saturation
        do_clr();
        for (int i = 0; i < 300; i++) sample(i % MOD);
        check("run_sat", run_len, 255);

        // glitch_count saturation
        do_clr();
        for (int i = 0; i < 300; i++) sample((i % 2 == 0) ? 10 : 100);
        check("gcnt_sat", glitch_count, GC_MAX);

        // Randomized stream
        do_clr();
        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: x = (m_prev + 1) % MOD;
                4, 5:       x = (m_prev + MOD - 1) % MOD;
                6:          x = m_prev;
                7:          x = 0;
                default:    x = $urandom_range(0, MOD - 1);
            endcase
            step($urandom_range(0, 3) != 0, x, $urandom_range(0, 49) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
